// File: rtl/rriscv_decode_stage_pkg.sv
// Shared types for the RV32/RV64 decode stage: operation codes, instruction formats,
// opcode/funct constants and per-format bit layouts of the 32-bit instruction word.
package rriscv_decode_stage_pkg;

  typedef enum logic [4:0] {
    ADD, SUB, XOR, OR, AND, MUL,
    ADDI, XORI, ORI, ANDI,
    LW, SW, LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE,
    ILLEGAL
  } op_t;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instr_r_t;

  typedef struct packed {
    logic [11:0] imm11_0;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } instr_i_t;

  typedef struct packed {
    logic [6:0] imm11_5;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] imm4_0;
    logic [6:0] opcode;
  } instr_s_t;

  typedef struct packed {
    logic       imm12;
    logic [5:0] imm10_5;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [3:0] imm4_1;
    logic       imm11;
    logic [6:0] opcode;
  } instr_b_t;

  typedef struct packed {
    logic [19:0] imm31_12;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } instr_u_t;

  typedef struct packed {
    logic       imm20;
    logic [9:0] imm10_1;
    logic       imm11;
    logic [7:0] imm19_12;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instr_j_t;

  typedef union packed {
    instr_r_t r;
    instr_i_t i;
    instr_s_t s;
    instr_b_t b;
    instr_u_t u;
    instr_j_t j;
  } instr_view_t;

endpackage

// File: rtl/rriscv_imm_gen.sv
// Combinational immediate extraction: selects the layout by format and sign-extends from
// instr[31] to XLEN; R-type (and anything unrecognised) yields zero.
module rriscv_imm_gen
  import rriscv_decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  fmt_t            fmt,
  output logic [XLEN-1:0] imm
);

  instr_view_t v;
  logic [31:0] imm32;
  logic        unused_opcode;

  assign v = instr_view_t'(instr);
  assign unused_opcode = ^v.r.opcode;

  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{20{v.i.imm11_0[11]}}, v.i.imm11_0};
      FMT_S:   imm32 = {{20{v.s.imm11_5[6]}}, v.s.imm11_5, v.s.imm4_0};
      FMT_B:   imm32 = {{19{v.b.imm12}}, v.b.imm12, v.b.imm11, v.b.imm10_5, v.b.imm4_1, 1'b0};
      FMT_U:   imm32 = {v.u.imm31_12, 12'h000};
      FMT_J:   imm32 = {{11{v.j.imm20}}, v.j.imm20, v.j.imm19_12, v.j.imm11, v.j.imm10_1, 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Every 32-bit layout already carries instr[31] in bit 31, so widening is a plain sign extension.
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/rriscv_decode_stage.sv
// Decode stage between fetch and execute: one registered cycle from accept to out_*.
// One-entry skid keeps full throughput under backpressure; in_ready is registered (!skid full).
module rriscv_decode_stage
  import rriscv_decode_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter bit EN_M  = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output op_t              out_op,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_pc,
  output logic [CNT_W-1:0] illegal_cnt,
  input  logic             cnt_clr
);

  logic            skid_vld;
  logic [31:0]     skid_instr;
  logic [XLEN-1:0] skid_pc;

  instr_r_t        src;
  logic [XLEN-1:0] src_pc;
  op_t             dec_op;
  fmt_t            dec_fmt;
  logic [4:0]      dec_rd, dec_rs1, dec_rs2;
  logic [XLEN-1:0] dec_imm;
  logic            accept, out_free;

  assign in_ready = !skid_vld;
  assign accept   = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;

  // A full skid blocks input, so one decoder serves both the skid and the live input.
  assign src    = instr_r_t'(skid_vld ? skid_instr : in_instr);
  assign src_pc = skid_vld ? skid_pc : in_pc;

  always_comb begin
    dec_op  = ILLEGAL;
    dec_fmt = FMT_R;
    case (src.opcode)
      OPC_OP: begin
        if (src.funct7 == F7_BASE) begin
          case (src.funct3)
            F3_ADD:  dec_op = ADD;
            F3_XOR:  dec_op = XOR;
            F3_OR:   dec_op = OR;
            F3_AND:  dec_op = AND;
            default: dec_op = ILLEGAL;
          endcase
        end else if (src.funct7 == F7_ALT && src.funct3 == F3_ADD) begin
          dec_op = SUB;
        end else if (EN_M && src.funct7 == F7_MULDIV && src.funct3 == F3_ADD) begin
          dec_op = MUL;
        end
      end
      OPC_OPIMM: begin
        dec_fmt = FMT_I;
        case (src.funct3)
          F3_ADD:  dec_op = ADDI;
          F3_XOR:  dec_op = XORI;
          F3_OR:   dec_op = ORI;
          F3_AND:  dec_op = ANDI;
          default: dec_op = ILLEGAL;
        endcase
      end
      OPC_LOAD: begin
        dec_fmt = FMT_I;
        if (src.funct3 == F3_W) dec_op = LW;
      end
      OPC_STORE: begin
        dec_fmt = FMT_S;
        if (src.funct3 == F3_W) dec_op = SW;
      end
      OPC_LUI:   begin dec_fmt = FMT_U; dec_op = LUI;   end
      OPC_AUIPC: begin dec_fmt = FMT_U; dec_op = AUIPC; end
      OPC_JAL:   begin dec_fmt = FMT_J; dec_op = JAL;   end
      OPC_JALR: begin
        dec_fmt = FMT_I;
        if (src.funct3 == F3_ADD) dec_op = JALR;
      end
      OPC_BRANCH: begin
        dec_fmt = FMT_B;
        case (src.funct3)
          F3_BEQ:  dec_op = BEQ;
          F3_BNE:  dec_op = BNE;
          F3_BLT:  dec_op = BLT;
          F3_BGE:  dec_op = BGE;
          default: dec_op = ILLEGAL;
        endcase
      end
      default: dec_op = ILLEGAL;
    endcase

    // Illegal words fall back to R format so the immediate generator emits zero.
    if (dec_op == ILLEGAL) dec_fmt = FMT_R;

    dec_rd  = (dec_op == ILLEGAL || dec_fmt == FMT_S || dec_fmt == FMT_B) ? 5'd0 : src.rd;
    dec_rs1 = (dec_op == ILLEGAL || dec_fmt == FMT_U || dec_fmt == FMT_J) ? 5'd0 : src.rs1;
    dec_rs2 = (dec_op == ILLEGAL || dec_fmt == FMT_I || dec_fmt == FMT_U || dec_fmt == FMT_J)
              ? 5'd0 : src.rs2;
  end

  rriscv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (src),
    .fmt   (dec_fmt),
    .imm   (dec_imm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      skid_vld   <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
      out_op     <= ADD;
      out_rd     <= '0;
      out_rs1    <= '0;
      out_rs2    <= '0;
      out_imm    <= '0;
      out_pc     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      skid_vld  <= 1'b0;
    end else if (out_free) begin
      out_valid <= skid_vld || accept;
      skid_vld  <= 1'b0;
      if (skid_vld || accept) begin
        out_op  <= dec_op;
        out_rd  <= dec_rd;
        out_rs1 <= dec_rs1;
        out_rs2 <= dec_rs2;
        out_imm <= dec_imm;
        out_pc  <= src_pc;
      end
    end else if (accept) begin
      skid_vld   <= 1'b1;
      skid_instr <= in_instr;
      skid_pc    <= in_pc;
    end
  end

  // With the skid empty whenever a beat is accepted, dec_op here describes the incoming word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (cnt_clr) begin
      illegal_cnt <= '0;
    end else if (accept && !flush && dec_op == ILLEGAL && illegal_cnt != '1) begin
      illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rriscv_decode_stage.sv
// Directed bench: two instances share stimulus (A: RV32, MUL on, 2-bit counter;
// B: RV64, MUL off, 16-bit counter) and are checked against hand-computed values.
module tb_rriscv_decode_stage;
  import rriscv_decode_stage_pkg::*;

  localparam logic [31:0] I_ADDI = 32'hFFF00093;
  localparam logic [31:0] I_SW   = 32'h0020A423;
  localparam logic [31:0] I_BNE  = 32'hFE209EE3;
  localparam logic [31:0] I_LUI  = 32'h123452B7;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_MUL  = 32'h022081B3;
  localparam logic [31:0] I_ILL  = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, flush, out_ready, cnt_clr;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  op_t         a_op, b_op;
  logic [4:0]  a_rd, a_rs1, a_rs2, b_rd, b_rs1, b_rs2;
  logic [31:0] a_imm, a_pc;
  logic [63:0] b_imm, b_pc;
  logic [1:0]  a_cnt;
  logic [15:0] b_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int bp_idx, bp_got;
  bit acc_now, take_now;

  always #5 clk = ~clk;

  rriscv_decode_stage #(.XLEN(32), .EN_M(1'b1), .CNT_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .flush(flush),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_op(a_op),
    .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_imm(a_imm), .out_pc(a_pc),
    .illegal_cnt(a_cnt), .cnt_clr(cnt_clr)
  );

  rriscv_decode_stage #(.XLEN(64), .EN_M(1'b0), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_op(b_op),
    .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_imm(b_imm), .out_pc(b_pc),
    .illegal_cnt(b_cnt), .cnt_clr(cnt_clr)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [63:0] pc);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    step();
    in_valid = 1'b0;
  endtask

  task automatic chk_dec(input string tag, input op_t op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    chk({tag, "_vld"}, a_out_valid, 1);
    chk({tag, "_op"},  a_op,  op);
    chk({tag, "_rd"},  a_rd,  rd);
    chk({tag, "_rs1"}, a_rs1, rs1);
    chk({tag, "_rs2"}, a_rs2, rs2);
    chk({tag, "_imm"}, a_imm, imm);
  endtask

  function automatic logic [31:0] addi_enc(input int k);
    logic [11:0] imm12;
    imm12 = 12'(k);
    return {imm12, 5'd0, 3'b000, 5'd1, 7'b0010011};
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    flush = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    #12;
    chk("rst_vld",   a_out_valid, 0);
    chk("rst_rdy",   a_in_ready, 1);
    chk("rst_cnt",   a_cnt, 0);
    chk("rst_imm",   a_imm, 0);
    chk("rst_b_vld", b_out_valid, 0);
    chk("rst_b_rdy", b_in_ready, 1);
    rst_n = 1'b1;
    step();

    issue(I_ADDI, 64'h100);
    chk_dec("addi", ADDI, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF);
    chk("addi_pc", a_pc, 32'h100);
    chk("addi_b_imm", b_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_b_pc", b_pc, 64'h100);
    issue(I_SW, 64'h104);
    chk_dec("sw", SW, 5'd0, 5'd1, 5'd2, 32'd8);
    issue(I_BNE, 64'h108);
    chk_dec("bne", BNE, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
    chk("bne_b_imm", b_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    issue(I_LUI, 64'h10C);
    chk_dec("lui", LUI, 5'd5, 5'd0, 5'd0, 32'h12345000);
    issue(I_JAL, 64'h110);
    chk_dec("jal", JAL, 5'd1, 5'd0, 5'd0, 32'd8);
    issue(I_MUL, 64'h114);
    chk_dec("mul", MUL, 5'd3, 5'd1, 5'd2, 32'd0);
    chk("mul_cnt", a_cnt, 0);
    chk("mul_b_op", b_op, ILLEGAL);
    chk("mul_b_rd", b_rd, 0);
    chk("mul_b_rs1", b_rs1, 0);
    chk("mul_b_rs2", b_rs2, 0);
    chk("mul_b_cnt", b_cnt, 1);
    step();
    chk("idle_vld", a_out_valid, 0);

    // Backpressure: consumer stalled for the first three cycles of the stream.
    bp_idx = 0;
    bp_got = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      out_ready = (cyc >= 3);
      in_valid  = (bp_idx < 4);
      in_instr  = addi_enc(bp_idx + 1);
      in_pc     = 64'h200 + 64'(4 * bp_idx);
      if (cyc == 1) chk("bp_rdy_c1", a_in_ready, 1);
      if (cyc == 2) chk("bp_rdy_c2", a_in_ready, 0);
      acc_now  = in_valid && a_in_ready;
      take_now = a_out_valid && out_ready;
      if (take_now) begin
        chk("bp_order", a_imm, 64'(bp_got + 1));
        bp_got++;
      end
      step();
      if (acc_now) bp_idx++;
    end
    in_valid = 1'b0;
    chk("bp_count", 64'(bp_got), 4);
    chk("bp_drained", a_out_valid, 0);

    // Flush with output and skid both full and an illegal word on the input.
    out_ready = 1'b0;
    issue(addi_enc(7), 64'h300);
    issue(addi_enc(8), 64'h304);
    chk("fl_pre_rdy", a_in_ready, 0);
    in_valid = 1'b1; in_instr = I_ILL; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_vld", a_out_valid, 0);
    chk("fl_rdy", a_in_ready, 1);
    // Flush in a cycle where the illegal beat is actually accepted.
    in_valid = 1'b1; in_instr = I_ILL; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl2_vld", a_out_valid, 0);
    chk("fl2_cnt", a_cnt, 0);
    chk("fl2_b_cnt", b_cnt, 1);
    out_ready = 1'b1;
    step();
    chk("fl_nothing", a_out_valid, 0);

    // Counter saturation on the 2-bit instance.
    for (int i = 0; i < 5; i++) begin
      issue(I_ILL, 64'h400);
      if (i == 0) chk_dec("ill", ILLEGAL, 5'd0, 5'd0, 5'd0, 32'd0);
      if (i == 1) chk("cnt_2", a_cnt, 2);
    end
    chk("cnt_sat", a_cnt, 3);
    chk("cnt_b_6", b_cnt, 6);
    cnt_clr = 1'b1;
    issue(I_ILL, 64'h404);
    cnt_clr = 1'b0;
    chk("cnt_clr", a_cnt, 0);
    chk("cnt_clr_b", b_cnt, 0);

    // Asynchronous reset while output and skid hold instructions.
    out_ready = 1'b0;
    issue(I_ILL, 64'h500);
    issue(addi_enc(9), 64'h504);
    chk("pre_rst_cnt", a_cnt, 1);
    chk("pre_rst_rdy", a_in_ready, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_vld", a_out_valid, 0);
    chk("arst_rdy", a_in_ready, 1);
    chk("arst_cnt", a_cnt, 0);
    chk("arst_imm", a_imm, 0);
    chk("arst_pc",  a_pc, 0);
    chk("arst_op",  a_op, ADD);
    chk("arst_b_vld", b_out_valid, 0);
    step();
    rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rriscv_decode_stage.md
Name: rriscv_decode_stage

Overview:
Parametrised RV32/RV64 instruction decode stage with valid/ready handshaking on both sides. It sits between the fetch stage and the execute stage. Each accepted instruction word is resolved into an operation code, register indices and a fully sign-extended XLEN immediate, registered with one cycle of latency. A skid buffer gives full throughput under backpressure, and a saturating counter tracks illegal instructions.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; sets imm/pc width.
EN_M, 1, 1 = MUL is decoded as legal; 0 = MUL decodes as illegal.
CNT_W, 16, width of the illegal-instruction counter.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  fetch presents an instruction.
in_ready  out  1  stage can accept this cycle.
in_instr  in  32  raw instruction word.
in_pc  in  XLEN  PC of in_instr.
flush  in  1  discard all held and incoming instructions.
out_valid  out  1  decoded instruction available.
out_ready  in  1  execute accepts.
out_op  out  op_t  decoded operation enum.
out_rd  out  5  destination register; 0 when none.
out_rs1  out  5  source 1; 0 when unused.
out_rs2  out  5  source 2; 0 when unused.
out_imm  out  XLEN  sign-extended immediate; 0 for R-type.
out_pc  out  XLEN  PC passthrough.
illegal_cnt  out  CNT_W  saturating count of illegal instructions.
cnt_clr  in  1  synchronous clear of illegal_cnt.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, skid empty, in_ready=1, illegal_cnt=0. All data outputs 0.
- Handshake: a beat transfers when valid&&ready. in_valid and out_valid, once high, hold until accepted. Data holds stable while valid&&!ready.
- Latency: an accepted instruction appears on out_* the next cycle when the output register is free or draining.
- Skid: if the output register is full, out_ready=0 and a beat is accepted, that beat goes to the one-entry skid. in_ready = !skid_full (registered). When the output drains, skid moves to output and the skid frees. Order is preserved. Sustained throughput is 1/cycle.
- Flush: clears output register and skid next cycle; out_valid=0. A beat accepted in the flush cycle is dropped and not counted. Flush has priority over accept and over skid transfer.
- Decode, op_t: ADD SUB XOR OR AND MUL ADDI XORI ORI ANDI LW SW LUI AUIPC JAL JALR BEQ BNE BLT BGE ILLEGAL, matched on opcode/funct3/funct7 per RV32I/M.
- Any other encoding is ILLEGAL, and so is MUL when EN_M=0. ILLEGAL forces rd=rs1=rs2=0 and imm=0, and still flows downstream.
- Immediates, sign-extended from inst[31] to XLEN:
  - I: inst[31:20].
  - S: {inst[31:25],inst[11:7]}.
  - B: {inst[31],inst[7],inst[30:25],inst[11:8],0}.
  - U: {inst[31:12],12'h0}.
  - J: {inst[31],inst[19:12],inst[20],inst[30:21],0}.
- Field zeroing: rd=0 for S/B. rs2=0 for I/U/J. rs1=0 for U/J.
- Counter: increments by 1 when an ILLEGAL instruction is accepted and the same cycle has no flush. It saturates at all ones. cnt_clr wins over a simultaneous increment (result 0).
- Reset mid-operation: all held instructions are lost immediately. No partial output is allowed.

Decomposition:
- Shared package: op_t enum; opcode/funct3/funct7 constants; instruction-format structs; immediate-layout structs (B, U, J to the standard layouts above).
- Sub-module: rriscv_imm_gen, a combinational (instr, fmt) -> XLEN immediate block.
- The decode and skid logic live in this module.

Test Plan:
- ADDI x1,x0,-1 (0xFFF00093), out_ready=1 -> next cycle: op=ADDI, rd=1, rs1=0, imm=0xFFFFFFFF (XLEN=32); with XLEN=64, imm=0xFFFFFFFFFFFFFFFF.
- SW x2,8(x1) (0x0020A423) -> op=SW, rd=0, rs1=1, rs2=2, imm=8. BNE x1,x2,-4 (0xFE209EE3) -> op=BNE, imm=0xFFFFFFFC. LUI x5,0x12345 (0x123452B7) -> op=LUI, rd=5, imm=0x12345000.
- EN_M=0, MUL x3,x1,x2 (0x022081B3) -> op=ILLEGAL, rd=0, illegal_cnt=1. With EN_M=1 -> op=MUL, rd=3, rs1=1, rs2=2, counter unchanged.
- Backpressure: stream 4 instrs with out_ready low for 3 cycles -> in_ready drops after 2 held. All 4 emerge in order once ready, and none is lost or duplicated.
- Flush with skid full and in_valid high -> next cycle out_valid=0, in_ready=1. The flushed-cycle beat is never output, even if illegal, and the counter does not change.
- Counter: with CNT_W=2, feed 5 illegal instrs -> illegal_cnt saturates at 3. Assert cnt_clr together with a 6th illegal -> 0. Async reset mid-stream -> all outputs 0 immediately.
